// File: rtl/ecp_sched_pkg.sv
// Shared types and constants for the modular add/sub scheduler.
// - NUM_REQ / REQ_ID_W : requester count and id width
// - OP_ADD / OP_SUB    : unit op encoding
// - tag_t              : in-flight tag {valid, id}
// - onehot()           : requester id -> one-hot strobe
package ecp_sched_pkg;
  localparam int NUM_REQ  = 4;
  localparam int REQ_ID_W = 2;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef struct packed {
    logic                valid;
    logic [REQ_ID_W-1:0] id;
  } tag_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [REQ_ID_W-1:0] id);
    logic [NUM_REQ-1:0] v;
    v     = '0;
    v[id] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_arbiter4.sv
// Combinational round-robin pick among 4 requesters.
// - i_req       : eligible requesters
// - i_ptr       : highest-priority requester this cycle
// - o_gnt_id    : first eligible id at or after i_ptr (wraps 3->0)
// - o_gnt_valid : any requester eligible
module rr_arbiter4
  import ecp_sched_pkg::*;
(
  input  logic [NUM_REQ-1:0]  i_req,
  input  logic [REQ_ID_W-1:0] i_ptr,
  output logic [REQ_ID_W-1:0] o_gnt_id,
  output logic                o_gnt_valid
);
  logic [REQ_ID_W-1:0] w_idx;

  // Scan from farthest to nearest offset so the nearest hit overwrites.
  // The 2-bit add wraps naturally modulo 4.
  always_comb begin
    o_gnt_id    = i_ptr;
    o_gnt_valid = 1'b0;
    w_idx       = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      w_idx = i_ptr + REQ_ID_W'(k);
      if (i_req[w_idx]) begin
        o_gnt_id    = w_idx;
        o_gnt_valid = 1'b1;
      end
    end
  end
endmodule

// File: rtl/mod_add_scheduler.sv
// Round-robin scheduler for one shared pipelined 256-bit modular add/sub unit.
// Only ids/tags move through here; operands and results bypass this block.
// - clk, reset  : clock, synchronous active-high reset
// - req_valid   : per-requester pending operation (held until accepted)
// - req_sub     : per-requester op (0 add, 1 sub), sampled on accept
// - req_ready   : requester may be accepted this cycle
// - flush       : drop all in-flight tags and pending bits
// - mux_select  : registered operand-mux select = issued requester id
// - issue_valid : registered unit input valid
// - issue_sub   : registered unit op
// - rsp_valid   : one-hot completion strobe, LATENCY cycles after issue
// - busy        : anything pending, in flight or requested
module mod_add_scheduler
  import ecp_sched_pkg::*;
#(
  parameter int LATENCY = 3
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_REQ-1:0]  req_valid,
  input  logic [NUM_REQ-1:0]  req_sub,
  output logic [NUM_REQ-1:0]  req_ready,
  input  logic                flush,
  output logic [REQ_ID_W-1:0] mux_select,
  output logic                issue_valid,
  output logic                issue_sub,
  output logic [NUM_REQ-1:0]  rsp_valid,
  output logic                busy
);
  tag_t [LATENCY-1:0]  r_tag;
  logic [NUM_REQ-1:0]  r_pend;
  logic [REQ_ID_W-1:0] r_ptr;
  logic [REQ_ID_W-1:0] r_mux_select;
  logic                r_issue_valid;
  logic                r_issue_sub;
  logic [NUM_REQ-1:0]  r_rsp_valid;

  logic [NUM_REQ-1:0]  w_elig;
  logic [REQ_ID_W-1:0] w_gnt_id;
  logic                w_gnt_valid;
  logic                w_tag_any;

  // Ready depends only on registered pending bits, so a requester whose
  // response is on the output this cycle is not re-accepted until the next.
  assign req_ready = ~r_pend & {NUM_REQ{~flush}};
  assign w_elig    = req_valid & req_ready;

  rr_arbiter4 u_arb (
    .i_req       (w_elig),
    .i_ptr       (r_ptr),
    .o_gnt_id    (w_gnt_id),
    .o_gnt_valid (w_gnt_valid)
  );

  always_comb begin
    w_tag_any = 1'b0;
    for (int k = 0; k < LATENCY; k++) w_tag_any = w_tag_any | r_tag[k].valid;
  end

  assign busy = (|r_pend) | w_tag_any | (|req_valid);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tag         <= '0;
      r_pend        <= '0;
      r_ptr         <= '0;
      r_mux_select  <= '0;
      r_issue_valid <= 1'b0;
      r_issue_sub   <= 1'b0;
      r_rsp_valid   <= '0;
    end else begin
      // Tag leaving the pipe becomes the response strobe unless flushed.
      r_rsp_valid <= (r_tag[LATENCY-1].valid && !flush) ? onehot(r_tag[LATENCY-1].id) : '0;
      for (int k = LATENCY - 1; k > 0; k--) r_tag[k] <= r_tag[k-1];
      // Flush forces req_ready low, so no grant can occur on a flush edge.
      r_tag[0]      <= {w_gnt_valid, w_gnt_id};
      r_pend        <= (r_pend & ~r_rsp_valid) | (w_gnt_valid ? onehot(w_gnt_id) : '0);
      r_issue_valid <= w_gnt_valid;
      if (w_gnt_valid) begin
        r_mux_select <= w_gnt_id;
        r_issue_sub  <= req_sub[w_gnt_id] ? OP_SUB : OP_ADD;
        r_ptr        <= w_gnt_id + 1'b1;
      end
      if (flush) begin
        r_pend <= '0;
        for (int k = 0; k < LATENCY; k++) r_tag[k].valid <= 1'b0;
      end
    end
  end

  assign mux_select  = r_mux_select;
  assign issue_valid = r_issue_valid;
  assign issue_sub   = r_issue_sub;
  assign rsp_valid   = r_rsp_valid;
endmodule

// File: tb/tb_mod_add_scheduler.sv
module tb_mod_add_scheduler;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       reset, flush;
  logic [3:0] req_valid, req_sub, req_ready, rsp_valid;
  logic [1:0] mux_select;
  logic       issue_valid, issue_sub, busy;

  always #5 clk = ~clk;

  mod_add_scheduler #(.LATENCY(LAT)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_sub(req_sub),
    .req_ready(req_ready), .flush(flush), .mux_select(mux_select),
    .issue_valid(issue_valid), .issue_sub(issue_sub), .rsp_valid(rsp_valid),
    .busy(busy)
  );

  int n_chk = 0, n_err = 0, cyc = 0;

  // Behavioural model: per-requester pending flag and the cycle its response
  // appears; expected registered outputs for the current cycle.
  int       m_ptr;
  bit [3:0] m_pend;
  int       m_due[4];
  bit       m_iv, m_is;
  bit [1:0] m_ms;
  bit [3:0] m_rsp;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", nm, cyc, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, check combinational outputs, advance the
  // model, then check the registered outputs of the next cycle.
  task automatic step(input logic [3:0] v, input logic [3:0] s, input logic f, input logic r);
    bit [3:0] nrsp;
    int g, idx;
    @(negedge clk);
    req_valid = v; req_sub = s; flush = f; reset = r;
    #1;
    if (!r) begin
      chk("req_ready", {4'b0, req_ready}, {4'b0, ~m_pend & {4{~f}}});
      chk("busy", {7'b0, busy}, {7'b0, (|m_pend) || (|v)});
    end
    if (r) begin
      m_ptr = 0; m_pend = 0; m_iv = 0; m_is = 0; m_ms = 0; m_rsp = 0;
      for (int i = 0; i < 4; i++) m_due[i] = -1;
    end else begin
      nrsp = 0;
      for (int i = 0; i < 4; i++) if (!f && m_due[i] == cyc + 1) nrsp[i] = 1'b1;
      g = -1;
      if (!f) begin
        for (int k = 0; k < 4; k++) begin
          idx = (m_ptr + k) % 4;
          if (g < 0 && v[idx] && !m_pend[idx]) g = idx;
        end
      end
      for (int i = 0; i < 4; i++) if (m_due[i] == cyc) begin m_pend[i] = 0; m_due[i] = -1; end
      if (f) begin
        m_pend = 0;
        for (int i = 0; i < 4; i++) m_due[i] = -1;
      end
      if (g >= 0) begin
        m_pend[g] = 1'b1; m_due[g] = cyc + 1 + LAT;
        m_iv = 1; m_ms = 2'(g); m_is = s[g]; m_ptr = (g + 1) % 4;
      end else m_iv = 0;
      m_rsp = nrsp;
    end
    @(posedge clk);
    cyc++;
    #1;
    chk("issue_valid", {7'b0, issue_valid}, {7'b0, m_iv});
    chk("mux_select", {6'b0, mux_select}, {6'b0, m_ms});
    chk("issue_sub", {7'b0, issue_sub}, {7'b0, m_is});
    chk("rsp_valid", {4'b0, rsp_valid}, {4'b0, m_rsp});
  endtask

  int       gq[$];
  bit [3:0] exp_rsp[4];
  bit       rf, ff;

  initial begin
    req_valid = 0; req_sub = 0; flush = 0; reset = 1;
    for (int i = 0; i < 4; i++) m_due[i] = -1;
    m_ptr = 0; m_pend = 0;

    // Reset state
    step(4'b0, 4'b0, 1'b0, 1'b1);
    chk("rst_outs", {issue_valid, issue_sub, mux_select, rsp_valid}, 8'h00);
    chk("rst_ready", {4'b0, req_ready}, 8'h0f);

    // Single request
    step(4'b0001, 4'b0, 1'b0, 1'b0);                 // t0 -> t1
    chk("single_issue", {issue_valid, 5'b0, mux_select}, 8'h80);
    chk("single_ready_t1", {7'b0, req_ready[0]}, 8'h0);
    step(4'b0, 4'b0, 1'b0, 1'b0);
    step(4'b0, 4'b0, 1'b0, 1'b0);
    step(4'b0, 4'b0, 1'b0, 1'b0);                    // -> t4
    chk("single_rsp_t4", {4'b0, rsp_valid}, 8'h01);
    chk("single_ready_t4", {7'b0, req_ready[0]}, 8'h0);
    step(4'b0, 4'b0, 1'b0, 1'b0);                    // -> t5
    chk("single_ready_t5", {7'b0, req_ready[0]}, 8'h1);

    // All four back-to-back
    step(4'b0, 4'b0, 1'b0, 1'b1);
    exp_rsp[0] = 4'b0001; exp_rsp[1] = 4'b0010; exp_rsp[2] = 4'b0100; exp_rsp[3] = 4'b1000;
    for (int t = 1; t <= 7; t++) begin
      step(4'b1111, 4'b0, 1'b0, 1'b0);
      if (t <= 4) chk("all4_sel", {7'b0, issue_valid, 6'b0, mux_select}, {7'b1, 6'b0, 2'(t - 1)});
      if (t >= 4) chk("all4_rsp", {4'b0, rsp_valid}, {4'b0, exp_rsp[t - 4]});
    end

    // Sub op
    step(4'b0, 4'b0, 1'b0, 1'b1);
    step(4'b0010, 4'b0010, 1'b0, 1'b0);
    chk("sub_issue", {issue_valid, issue_sub, 4'b0, mux_select}, 8'hc1);

    // Fairness: 0 and 2 held high
    step(4'b0, 4'b0, 1'b0, 1'b1);
    for (int t = 0; t < 24; t++) begin
      step(4'b0101, 4'b0, 1'b0, 1'b0);
      if (issue_valid) gq.push_back(int'(mux_select));
    end
    chk("fair_count_ge6", {7'b0, gq.size() >= 6}, 8'h1);
    if (gq.size() >= 2) begin
      chk("fair_first", 8'(gq[0]), 8'h0);
      chk("fair_second", 8'(gq[1]), 8'h2);
    end
    for (int i = 1; i < gq.size(); i++) chk("fair_alt", 8'(gq[i]), 8'(gq[i - 1] ^ 2));

    // Flush with three tags in flight
    step(4'b0, 4'b0, 1'b0, 1'b1);
    step(4'b0111, 4'b0, 1'b0, 1'b0);
    step(4'b0111, 4'b0, 1'b0, 1'b0);
    step(4'b0111, 4'b0, 1'b0, 1'b0);
    step(4'b0, 4'b0, 1'b1, 1'b0);
    req_valid = 0; flush = 0; #1;
    chk("flush_ready", {4'b0, req_ready}, 8'h0f);
    chk("flush_busy", {7'b0, busy}, 8'h0);
    chk("flush_noissue", {7'b0, issue_valid}, 8'h0);
    for (int t = 0; t < 5; t++) begin
      step(4'b0, 4'b0, 1'b0, 1'b0);
      chk("flush_norsp", {4'b0, rsp_valid}, 8'h0);
    end

    // Reset mid-operation, pointer restarts
    step(4'b1111, 4'b0, 1'b0, 1'b0);
    step(4'b1111, 4'b0, 1'b0, 1'b0);
    step(4'b1111, 4'b1111, 1'b1, 1'b1);
    chk("midrst_outs", {issue_valid, issue_sub, mux_select, rsp_valid}, 8'h00);
    for (int t = 0; t < 5; t++) begin
      step(4'b0, 4'b0, 1'b0, 1'b0);
      chk("midrst_norsp", {4'b0, rsp_valid}, 8'h0);
    end
    step(4'b1111, 4'b0, 1'b0, 1'b0);
    chk("midrst_ptr0", {issue_valid, 5'b0, mux_select}, 8'h80);

    // Randomized traffic
    for (int t = 0; t < 600; t++) begin
      rf = ($urandom_range(0, 49) == 0);
      ff = ($urandom_range(0, 19) == 0);
      step(4'($urandom), 4'($urandom), ff, rf);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
